// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM. Sequences fetch, decode, memory, ALU,
// branch and jump steps over a shared datapath. Memory steps wait on the
// MemReady handshake. The block also exports debug state, a count of
// retired instructions and a pulse flagging unsupported opcodes.
module multicycle_controller #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [5:0]             Opcode,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic [3:0]             State,
  output logic [COUNT_WIDTH-1:0] InstrCount,
  output logic                   IllegalOp
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     state;
  state_t     state_next;
  logic [5:0] opcode_q;
  logic       retire;
  logic       illegal_next;

  // Branch gating on Zero happens in the datapath, so the FSM ignores it.
  logic unused_zero;
  assign unused_zero = Zero;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge Clk) begin
    if (!Rst) state <= FETCH;
    else      state <= state_next;
  end

  // Latched opcode, retired-instruction counter and illegal-opcode pulse.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      opcode_q   <= '0;
      InstrCount <= '0;
      IllegalOp  <= 1'b0;
    end else begin
      if (state == DECODE) opcode_q <= Opcode;
      if (retire)          InstrCount <= InstrCount + 1'b1;
      IllegalOp <= illegal_next;
    end
  end

  // Next-state selection, retire detection and Moore control outputs.
  always_comb begin
    state_next   = FETCH;
    retire       = 1'b0;
    illegal_next = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        state_next = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:     state_next = EXEC;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_ADDI:      state_next = ADDIEX;
          default: begin
            state_next   = FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (opcode_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        state_next = MemReady ? FETCH : MEMWR;
        retire     = MemReady;
      end
      EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: state_next = FETCH;
    endcase
    if (!Rst) begin
      retire       = 1'b0;
      illegal_next = 1'b0;
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 1'b0;
      RegDst       = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      PCSource     = 2'b00;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instruction sequences plus
// randomized instructions and memory wait counts, compared cycle by cycle
// against a path/control-table model of the controller.
module tb_multicycle_controller;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [5:0] Opcode = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic [15:0] InstrCount;
  logic IllegalOp;

  logic wPCWrite, wPCWriteCond, wIorD, wMemRead, wMemWrite, wIRWrite;
  logic wMemtoReg, wRegDst, wRegWrite, wALUSrcA;
  logic [1:0] wALUSrcB, wALUOp, wPCSource;
  logic [3:0] wState;
  logic [3:0] wInstrCount;
  logic wIllegalOp;

  int total = 0;
  int bad = 0;
  int modelCount = 0;
  bit pendingIllegal = 0;

  always #5 Clk = ~Clk;

  multicycle_controller #(.COUNT_WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .InstrCount(InstrCount), .IllegalOp(IllegalOp)
  );

  multicycle_controller #(.COUNT_WIDTH(4)) dutw (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(wPCWrite), .PCWriteCond(wPCWriteCond), .IorD(wIorD),
    .MemRead(wMemRead), .MemWrite(wMemWrite), .IRWrite(wIRWrite),
    .MemtoReg(wMemtoReg), .RegDst(wRegDst), .RegWrite(wRegWrite),
    .ALUSrcA(wALUSrcA), .ALUSrcB(wALUSrcB), .ALUOp(wALUOp), .PCSource(wPCSource),
    .State(wState), .InstrCount(wInstrCount), .IllegalOp(wIllegalOp)
  );

  // Control word order:
  // PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource
  function automatic logic [15:0] ctrlExp(input int st, input bit mr);
    case (st)
      0:  return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      3:  return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      5:  return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      6:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      8:  return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      9:  return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
      10: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      11: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ctrlObs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs just after the edge, compare on the falling edge.
  task automatic applyStimulus(input int expState, input bit mr, input logic [5:0] op, input bit expIll);
    MemReady = mr;
    Opcode   = op;
    Zero     = 1'($urandom_range(0, 1));
    @(negedge Clk);
    checkOutput($sformatf("state(exp %0d)", expState), 32'(State), 32'(expState));
    checkOutput($sformatf("ctrl(st %0d)", expState), 32'(ctrlObs()), 32'(ctrlExp(expState, mr)));
    checkOutput("count16", 32'(InstrCount), 32'(modelCount % 65536));
    checkOutput("count4", 32'(wInstrCount), 32'(modelCount % 16));
    checkOutput("wstate", 32'(wState), 32'(expState));
    checkOutput("illegal", 32'(IllegalOp), 32'(expIll));
    @(posedge Clk);
    #1;
  endtask

  // Runs one instruction with fw fetch waits and mw memory waits; a limit
  // shorter than the full path stops early without retiring.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input int limit);
    int  sq[$];
    bit  mq[$];
    bit  legal;
    bit  ill;
    for (int i = 0; i < fw; i++) begin sq.push_back(0); mq.push_back(0); end
    sq.push_back(0); mq.push_back(1);
    sq.push_back(1); mq.push_back(1'($urandom_range(0, 1)));
    legal = 1;
    case (op)
      6'b100011: begin
        sq.push_back(2); mq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sq.push_back(3); mq.push_back(0); end
        sq.push_back(3); mq.push_back(1);
        sq.push_back(4); mq.push_back(1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        sq.push_back(2); mq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sq.push_back(5); mq.push_back(0); end
        sq.push_back(5); mq.push_back(1);
      end
      6'b000000: begin sq.push_back(6); mq.push_back(1); sq.push_back(7); mq.push_back(0); end
      6'b000100: begin sq.push_back(8); mq.push_back(0); end
      6'b000010: begin sq.push_back(9); mq.push_back(1); end
      6'b001000: begin sq.push_back(10); mq.push_back(0); sq.push_back(11); mq.push_back(1); end
      default:   legal = 0;
    endcase
    for (int i = 0; i < sq.size() && i < limit; i++) begin
      ill = pendingIllegal && (i == 0);
      if (i == 0) pendingIllegal = 0;
      applyStimulus(sq[i], mq[i], (sq[i] == 1) ? op : 6'($urandom), ill);
    end
    if (limit >= sq.size()) begin
      if (legal) modelCount++;
      else       pendingIllegal = 1;
    end
  endtask

  task automatic doReset();
    Rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      MemReady = 1'($urandom_range(0, 1));
      Opcode   = 6'($urandom);
      @(negedge Clk);
      checkOutput("reset ctrl", 32'(ctrlObs()), 32'h0);
      if (k > 0) begin
        checkOutput("reset state", 32'(State), 32'h0);
        checkOutput("reset count", 32'(InstrCount), 32'h0);
        checkOutput("reset illegal", 32'(IllegalOp), 32'h0);
      end
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;
    modelCount = 0;
    pendingIllegal = 0;
  endtask

  initial begin
    logic [5:0] legalOps [6];
    logic [5:0] illegalOps [4];
    legalOps   = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    illegalOps = '{6'b111111, 6'b000001, 6'b100000, 6'b001111};

    @(posedge Clk);
    #1;
    doReset();

    runInstr(6'b100011, 0, 0, 99);
    runInstr(6'b101011, 0, 2, 99);
    runInstr(6'b000000, 0, 0, 99);
    runInstr(6'b000100, 0, 0, 99);
    runInstr(6'b000010, 0, 0, 99);
    runInstr(6'b111111, 0, 0, 99);
    runInstr(6'b001000, 0, 0, 99);
    runInstr(6'b100011, 3, 1, 99);

    // Abort an lw while it waits in MEMRD.
    runInstr(6'b100011, 0, 3, 4);
    doReset();

    for (int n = 0; n < 17; n++) runInstr(6'b000010, 0, 0, 99);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        runInstr(illegalOps[$urandom_range(0, 3)], $urandom_range(0, 2), 0, 99);
      else
        runInstr(legalOps[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), 99);
    end

    runInstr(6'b101011, 1, 4, 3);
    doReset();
    runInstr(6'b000000, 0, 0, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the multi-cycle MIPS datapath: PC, IR, register file, ALU and shared instruction/data memory.
- Handles R-type, lw, sw, beq, j and addi. It replaces the single-cycle opcode decoder when the datapath is shared across cycles.
- Memory accesses use a ready handshake, so variable-latency memory is tolerated.
- Also exports the current state, a retired-instruction counter and an illegal-opcode flag for debug.

Parameters:
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  synchronous, active-low reset.
- Opcode  input  6  instruction bits [31:26], taken from the IR.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completed the current read or write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load when Zero=1.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  IR load.
- MemtoReg  output  1  register-file write data select: 0=ALUOut, 1=MDR.
- RegDst  output  1  destination select: 0=rt, 1=rd.
- RegWrite  output  1  register-file write enable.
- ALUSrcA  output  1  ALU A select: 0=PC, 1=regA.
- ALUSrcB  output  2  ALU B select: 00=regB, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
- ALUOp  output  2  00=add, 01=subtract, 10=funct-decoded.
- PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- State  output  4  current state encoding.
- InstrCount  output  COUNT_WIDTH  number of retired instructions.
- IllegalOp  output  1  one-cycle pulse when an unsupported opcode is seen.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 go to FETCH on the next edge.
- Reset: when Rst=0 at a rising edge:
  - State becomes FETCH; the latched opcode, InstrCount and IllegalOp become 0.
  - While Rst=0, every control output is forced to 0 combinationally.
  - In the first cycle after release, FETCH outputs are driven.
  - Reset asserted in the middle of an instruction aborts it; no partial retire is counted.
- Control outputs not listed for a state are 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=MemReady and PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch-target precompute).
  - Latches Opcode into an internal register; later states use only the latched copy.
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → ADDIEX
    - any other opcode → FETCH, and IllegalOp=1 for exactly the following cycle.
- MEMADR: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: drives MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: drives RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH and retires.
- MEMWR: drives MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH and retires.
- EXEC: drives ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: drives RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH and retires.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Goes to FETCH and retires whether or not the branch is taken.
  - The datapath performs the gating on Zero; Zero does not affect the controller's transitions.
- JUMP: drives PCWrite=1, PCSource=10. Goes to FETCH and retires.
- ADDIEX: drives ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB: drives RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH and retires.
- Retire: InstrCount increments by 1 on the edge that leaves a retiring state. It wraps from all-ones to 0. An illegal opcode does not retire.
- Memory handshake:
  - MemRead and MemWrite are never asserted together.
  - Requests are held steady while waiting, for any number of cycles, with no timeout.
- Latency with zero-wait memory (MemReady tied to 1):
  - lw = 5 cycles; sw, R-type and addi = 4 cycles; beq and j = 3 cycles.
  - Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle.

Test Plan:
- Reset: hold Rst=0 for 3 cycles in a random state, then release → all controls 0 during reset; State=0, InstrCount=0; the next cycle shows MemRead=1, ALUSrcB=01.
- lw with MemReady=1: Opcode=100011 → State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrCount=1.
- sw with MemReady low for 2 cycles in MEMWR → State sequence 0,1,2,5,5,5,0; MemWrite held high for 3 cycles; IorD=1 throughout; InstrCount +1.
- R-type then beq then j: Opcodes 000000, 000100, 000010 → states 6,7 then 8 (PCWriteCond=1, PCSource=01) then 9 (PCWrite=1, PCSource=10); InstrCount=3 after 10 cycles.
- Illegal opcode: Opcode=111111 → DECODE goes to FETCH; IllegalOp high for exactly 1 cycle; InstrCount unchanged. Then Opcode=001000 → states 10,11; RegDst=0, RegWrite=1.
- Wrap: COUNT_WIDTH=4, retire 17 j instructions → InstrCount=1. Opcode changed mid-instruction after DECODE → path follows the latched opcode.
